barrett_an_decoder_pipe: RTL

- Pipelined, parametrised AN-code decoder using Barrett reduction.
- Splits each received codeword x into quotient q = floor(x/A) and residue r = x mod A.
- Flags a detected error when r != 0 and keeps a saturating count of errored words.
- Sits between the channel receive buffer and downstream decode/correction logic, with a valid/ready stream on both sides.

---
 rtl/barrett_an_decoder_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/barrett_an_decoder_pipe.sv
// AN-code decoder: three-stage Barrett reduction pipeline that splits x into
// floor(x/A) and x mod A, flags r != 0 and keeps a saturating error count.
module barrett_an_decoder_pipe #(
  parameter int unsigned CW_W  = 6,
  parameter int unsigned A     = 13,
  parameter int unsigned A_W   = 4,
  parameter int unsigned Q_W   = 3,
  parameter int unsigned K     = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW_W-1:0]  in_codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   out_q,
  output logic [A_W-1:0]   out_r,
  output logic             out_error,
  output logic [CW_W-1:0]  out_receive,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_cnt_clr
);

  localparam int unsigned MU     = (2 ** K) / A;
  localparam int unsigned PROD_W = CW_W + K;
  localparam int unsigned RT_W   = A_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1: codeword and quotient estimate
  logic            s1_v_q;
  logic [CW_W-1:0] s1_x_q;
  logic [CW_W-1:0] s1_qe_q;
  logic [CW_W-1:0] s1_qe_d;

  // Stage 2: codeword, estimate and partial remainder in [0, 2A)
  logic            s2_v_q;
  logic [CW_W-1:0] s2_x_q;
  logic [CW_W-1:0] s2_qe_q;
  logic [RT_W-1:0] s2_rt_q;
  logic [RT_W-1:0] s2_rt_d;

  // Stage 3: corrected result, drives the outputs
  logic            s3_v_q;
  logic [CW_W-1:0] s3_x_q;
  logic [Q_W-1:0]  s3_q_q;
  logic [Q_W-1:0]  s3_q_d;
  logic [A_W-1:0]  s3_r_q;
  logic [A_W-1:0]  s3_r_d;
  logic            s3_err_q;
  logic            s3_err_d;
  logic            s3_fix;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_inc;

  logic s1_en;
  logic s2_en;
  logic s3_en;

  // A stage loads when it is empty or its content moves on this edge.
  always_comb begin
    s3_en = !s3_v_q || out_ready;
    s2_en = !s2_v_q || s3_en;
    s1_en = !s1_v_q || s2_en;
  end

  assign in_ready = s1_en;

  always_comb begin
    s1_qe_d = CW_W'((PROD_W'(in_codeword) * PROD_W'(MU)) >> K);
  end

  always_comb begin
    s2_rt_d = RT_W'(PROD_W'(s1_x_q) - (PROD_W'(s1_qe_q) * PROD_W'(A)));
  end

  // The estimate is at most one short, so a single conditional subtract fixes it.
  always_comb begin
    s3_fix   = (s2_rt_q >= RT_W'(A));
    s3_q_d   = Q_W'(s3_fix ? (s2_qe_q + CW_W'(1)) : s2_qe_q);
    s3_r_d   = A_W'(s3_fix ? (s2_rt_q - RT_W'(A)) : s2_rt_q);
    s3_err_d = (s3_r_d != '0);
  end

  // Clear wins over the old value but still counts a coincident errored transfer.
  always_comb begin
    cnt_inc = s3_v_q && out_ready && s3_err_q;
    cnt_d   = cnt_q;
    if (err_cnt_clr) begin
      cnt_d = CNT_W'(cnt_inc);
    end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_x_q   <= '0;
      s1_qe_q  <= '0;
      s2_v_q   <= 1'b0;
      s2_x_q   <= '0;
      s2_qe_q  <= '0;
      s2_rt_q  <= '0;
      s3_v_q   <= 1'b0;
      s3_x_q   <= '0;
      s3_q_q   <= '0;
      s3_r_q   <= '0;
      s3_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (s1_en) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_x_q  <= in_codeword;
          s1_qe_q <= s1_qe_d;
        end
      end
      if (s2_en) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_x_q  <= s1_x_q;
          s2_qe_q <= s1_qe_q;
          s2_rt_q <= s2_rt_d;
        end
      end
      if (s3_en) begin
        s3_v_q <= s2_v_q;
        if (s2_v_q) begin
          s3_x_q   <= s2_x_q;
          s3_q_q   <= s3_q_d;
          s3_r_q   <= s3_r_d;
          s3_err_q <= s3_err_d;
        end
      end
      cnt_q <= cnt_d;
    end
  end

  assign out_valid   = s3_v_q;
  assign out_q       = s3_q_q;
  assign out_r       = s3_r_q;
  assign out_error   = s3_err_q;
  assign out_receive = s3_x_q;
  assign err_cnt     = cnt_q;

endmodule
